wb_stage: RTL and testbench
===========================

# wb_stage

MEM/WB pipeline register and writeback stage of the pipelined CPU. It latches the memory-stage results, extracts and extends load data, and selects the writeback value. It drives the register file write port (rd, indata, we) and keeps a 64-bit retired-instruction counter. Its outputs are combinational from its own registers, so the register file write and the register file's same-cycle read bypass both see them in the cycle after capture.

## Interface
- XLEN, 32, datapath width. Only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold the MEM/WB register.
- flush  in  1  load a bubble into the MEM/WB register.
- in_valid  in  1  the memory stage holds a real instruction.
- in_rd  in  5  destination register.
- in_regwrite  in  1  the instruction writes rd.
- in_wbsel  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 reserved (treated as ALU).
- in_funct3  in  3  load type.
- in_alu_result  in  32  ALU result; also the load address.
- in_mem_rdata  in  32  word-aligned data-memory read word.
- in_pc4  in  32  PC+4 for JAL/JALR.
- wb_valid  out  1  registered valid.
- wb_rd  out  5  register file rd.
- wb_data  out  32  register file indata.
- wb_we  out  1  register file we.
- instret  out  64  count of retired instructions.

## Operation
- On each posedge, apply the first matching rule:
  - reset: clear all registered fields to 0 and clear instret to 0.
  - flush: clear the valid register to 0. Other fields are don't-care, but hold them.
  - stall: hold all registers.
  - otherwise: capture all in_* signals.
- Flush has priority over stall.
- wb_we = wb_valid & regwrite_q & (rd_q != 0). Writes to x0 are always suppressed.
- wb_rd = rd_q.
- wb_data depends on wbsel_q:
  - 01: the load-aligned value.
  - 10: pc4_q.
  - 00 and 11: alu_q.
- Load alignment uses byte offset off = alu_q[1:0]:
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend halfword[off[1]]; off[0] is ignored.
  - 101 LHU: zero-extend halfword[off[1]]; off[0] is ignored.
  - 010 LW and the unused codes 011/110/111: the full word, with off ignored.
  - Byte 0 is rdata[7:0] (little-endian).
- instret increments by 1 on a posedge with wb_valid=1, stall=0 and reset=0. That is the cycle the instruction leaves WB.
- instret wraps from 2^64−1 to 0.
- A stalled valid instruction keeps wb_we asserted on every stalled cycle. This repeats an idempotent write, and the design accepts it.

## Timing
- Reset values: wb_valid 0, wb_rd 0, wb_data 0, wb_we 0, instret 0.
- Latency is 1 cycle from in_* to wb_*. The register file write lands on the following posedge.
- A reader in the cycle after capture receives wb_data through the register file bypass.
- Stall and flush apply at the same edge.
- A reset in the middle of a stall or flush discards the held instruction and clears instret.
- Back-to-back valid instructions with stall=0 retire one per cycle; instret rises by 1 per cycle.

## Structure
- A shared package `cpu_pkg` holds:
  - WBSEL_ALU=2'b00, WBSEL_MEM=2'b01, WBSEL_PC4=2'b10.
  - F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101.
- One combinational sub-module, `load_align`, with inputs rdata[31:0], off[1:0], funct3[2:0] and output data[31:0].
- The top level holds the MEM/WB register, the writeback mux and instret.

## Test plan
- Reset: hold reset for 2 cycles with random inputs -> wb_valid=0, wb_we=0, wb_data=0, instret=0.
- ALU path: in_valid=1, rd=5, regwrite=1, wbsel=00, alu=0x1234_5678 -> next cycle wb_we=1, wb_rd=5, wb_data=0x1234_5678; instret becomes 1 one cycle later.
- Loads with rdata=0x80FF_7F01:
  - LB off=2 -> 0xFFFF_FFFF.
  - LBU off=3 -> 0x0000_0080.
  - LH off=0 -> 0x0000_7F01.
  - LHU off=2 -> 0x0000_80FF.
  - LW -> 0x80FF_7F01.
- x0 and PC+4:
  - rd=0, regwrite=1 -> wb_we=0, and instret still increments.
  - wbsel=10, pc4=0x0000_0104 -> wb_data=0x0000_0104.
- Stall then flush: capture a valid instruction, then stall for 3 cycles -> outputs hold and instret does not change. Then assert stall and flush together -> wb_valid=0 and instret does not increment.
- Wrap: force instret to 0xFFFF_FFFF_FFFF_FFFF and retire one instruction -> instret becomes 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the MEM/WB pipeline record.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            regwrite;
    logic [1:0]      wbsel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc4;
  } memwb_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a word-aligned load and extends it.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    byte_v = rdata[7:0];
    case (off)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data = {24'b0, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LHU:  data = {16'b0, half_v};
      default: data = rdata; // LW and unused codes return the full word
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback mux and retired-instruction counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN // only 32 is supported
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic [1:0]      in_wbsel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_pc4,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [63:0]     instret
);

  memwb_t      memwb_q, memwb_d;
  logic [63:0] instret_q, instret_d;
  logic [31:0] load_data;

  always_comb begin
    memwb_d   = memwb_q;
    instret_d = instret_q;
    // The instruction in WB retires on any edge where it is not held.
    if (memwb_q.valid && !stall) instret_d = instret_q + 64'd1;
    if (flush) begin
      memwb_d.valid = 1'b0;
    end else if (!stall) begin
      memwb_d = '{valid:    in_valid,
                  rd:       in_rd,
                  regwrite: in_regwrite,
                  wbsel:    in_wbsel,
                  funct3:   in_funct3,
                  alu:      in_alu_result,
                  rdata:    in_mem_rdata,
                  pc4:      in_pc4};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_q   <= '0;
      instret_q <= '0;
    end else begin
      memwb_q   <= memwb_d;
      instret_q <= instret_d;
    end
  end

  load_align u_load_align (
    .rdata  (memwb_q.rdata),
    .off    (memwb_q.alu[1:0]),
    .funct3 (memwb_q.funct3),
    .data   (load_data)
  );

  always_comb begin
    case (memwb_q.wbsel)
      WBSEL_MEM: wb_data = load_data;
      WBSEL_PC4: wb_data = memwb_q.pc4;
      default:   wb_data = memwb_q.alu; // ALU and the reserved code
    endcase
  end

  assign wb_valid = memwb_q.valid;
  assign wb_rd    = memwb_q.rd;
  assign wb_we    = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != 5'd0);
  assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors, corner sequences, random vs. model.
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbsel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_mem_rdata, in_pc4;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_wbsel(in_wbsel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_pc4(in_pc4),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .instret(instret)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the instruction currently in writeback plus the counter.
  logic        m_valid, m_regwrite;
  logic [4:0]  m_rd;
  logic [1:0]  m_wbsel;
  logic [2:0]  m_f3;
  logic [31:0] m_alu, m_rdata, m_pc4;
  logic [63:0] m_instret;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int unsigned boff = addr % 4;
    int unsigned hoff = (addr % 4) / 2;
    logic [31:0] b = (w >> (8 * boff)) & 32'hFF;
    logic [31:0] h = (w >> (16 * hoff)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_data();
    if (m_wbsel == 2'b01) return ref_load(m_rdata, m_alu, m_f3);
    if (m_wbsel == 2'b10) return m_pc4;
    return m_alu;
  endfunction

  task automatic model_edge();
    if (reset) begin
      {m_valid, m_regwrite, m_rd, m_wbsel, m_f3} = '0;
      {m_alu, m_rdata, m_pc4} = '0;
      m_instret = '0;
    end else begin
      if (m_valid && !stall) m_instret = m_instret + 64'd1;
      if (flush) m_valid = 1'b0;
      else if (!stall) begin
        m_valid = in_valid; m_regwrite = in_regwrite; m_rd = in_rd;
        m_wbsel = in_wbsel; m_f3 = in_funct3; m_alu = in_alu_result;
        m_rdata = in_mem_rdata; m_pc4 = in_pc4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
    check({tag, ".instret"}, instret, m_instret);
    if (m_valid) begin
      check({tag, ".we"}, 64'(wb_we), 64'(m_regwrite && m_rd != 5'd0));
      check({tag, ".rd"}, 64'(wb_rd), 64'(m_rd));
      check({tag, ".data"}, 64'(wb_data), 64'(ref_data()));
    end else begin
      check({tag, ".we"}, 64'(wb_we), 64'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4);
    in_valid = v; in_rd = rd; in_regwrite = rw; in_wbsel = sel; in_funct3 = f3;
    in_alu_result = alu; in_mem_rdata = rdata; in_pc4 = pc4;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
          $urandom, $urandom, $urandom);
  endtask

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] saved_instret;
  logic [31:0] saved_data;
  logic [4:0]  saved_rd;

  initial begin
    localparam logic [31:0] RD = 32'h80FF_7F01;
    vecs.push_back('{"alu",     1, 5'd5,  1, 2'b00, 3'b010, 32'h1234_5678, RD, 32'h0, 32'h1234_5678, 1});
    vecs.push_back('{"lb_off2", 1, 5'd6,  1, 2'b01, 3'b000, 32'h1000_0002, RD, 32'h0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{"lbu_off3",1, 5'd7,  1, 2'b01, 3'b100, 32'h1000_0003, RD, 32'h0, 32'h0000_0080, 1});
    vecs.push_back('{"lh_off0", 1, 5'd8,  1, 2'b01, 3'b001, 32'h1000_0000, RD, 32'h0, 32'h0000_7F01, 1});
    vecs.push_back('{"lhu_off2",1, 5'd9,  1, 2'b01, 3'b101, 32'h1000_0002, RD, 32'h0, 32'h0000_80FF, 1});
    vecs.push_back('{"lw",      1, 5'd10, 1, 2'b01, 3'b010, 32'h1000_0001, RD, 32'h0, 32'h80FF_7F01, 1});
    vecs.push_back('{"lb_off1", 1, 5'd11, 1, 2'b01, 3'b000, 32'h1000_0001, RD, 32'h0, 32'h0000_007F, 1});
    vecs.push_back('{"lh_off3", 1, 5'd12, 1, 2'b01, 3'b001, 32'h1000_0003, RD, 32'h0, 32'hFFFF_80FF, 1});
    vecs.push_back('{"f3_111",  1, 5'd13, 1, 2'b01, 3'b111, 32'h1000_0002, RD, 32'h0, 32'h80FF_7F01, 1});
    vecs.push_back('{"x0",      1, 5'd0,  1, 2'b00, 3'b010, 32'hDEAD_BEEF, RD, 32'h0, 32'hDEAD_BEEF, 0});
    vecs.push_back('{"pc4",     1, 5'd1,  1, 2'b10, 3'b010, 32'h5555_0000, RD, 32'h0000_0104, 32'h0000_0104, 1});
    vecs.push_back('{"sel11",   1, 5'd2,  1, 2'b11, 3'b000, 32'hCAFE_0001, RD, 32'h0000_0104, 32'hCAFE_0001, 1});
    vecs.push_back('{"no_rw",   1, 5'd3,  0, 2'b00, 3'b010, 32'h0000_0033, RD, 32'h0, 32'h0000_0033, 0});
    vecs.push_back('{"bubble",  0, 5'd4,  1, 2'b00, 3'b010, 32'h0000_0044, RD, 32'h0, 32'h0000_0044, 0});

    // Reset held for two cycles with random inputs.
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_random();
    step(); drive_random(); step();
    check("reset.valid", 64'(wb_valid), 64'd0);
    check("reset.we", 64'(wb_we), 64'd0);
    check("reset.data", 64'(wb_data), 64'd0);
    check("reset.rd", 64'(wb_rd), 64'd0);
    check("reset.instret", instret, 64'd0);
    reset = 1'b0;

    // Directed vectors, back-to-back; instret rises by one per retired vector.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].rw, vecs[i].sel, vecs[i].f3,
            vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
      step();
      check({vecs[i].name, ".data"}, 64'(wb_data), 64'(vecs[i].exp_data));
      check({vecs[i].name, ".we"}, 64'(wb_we), 64'(vecs[i].exp_we));
      check({vecs[i].name, ".rd"}, 64'(wb_rd), 64'(vecs[i].rd));
      check({vecs[i].name, ".instret"}, instret, 64'(i));
    end
    drive(0, 5'd0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    step();
    check("vecs.final_instret", instret, 64'(vecs.size() - 1));

    // Stall three cycles, then stall and flush together.
    drive(1, 5'd17, 1, 2'b00, 3'b010, 32'hA5A5_0017, 32'h0, 32'h0);
    step();
    saved_instret = instret; saved_data = 32'hA5A5_0017; saved_rd = 5'd17;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step();
      check("stall.we", 64'(wb_we), 64'd1);
      check("stall.data", 64'(wb_data), 64'(saved_data));
      check("stall.rd", 64'(wb_rd), 64'(saved_rd));
      check("stall.instret", instret, saved_instret);
    end
    flush = 1'b1;
    step();
    check("stall_flush.valid", 64'(wb_valid), 64'd0);
    check("stall_flush.we", 64'(wb_we), 64'd0);
    check("stall_flush.instret", instret, saved_instret);
    stall = 1'b0; flush = 1'b0;

    // Reset during a stall discards the held instruction and clears the counter.
    drive(1, 5'd9, 1, 2'b00, 3'b010, 32'h1, 32'h0, 32'h0);
    step();
    stall = 1'b1; reset = 1'b1;
    step();
    check("reset_in_stall.valid", 64'(wb_valid), 64'd0);
    check("reset_in_stall.instret", instret, 64'd0);
    stall = 1'b0; reset = 1'b0;

    // Counter wrap from all-ones.
    drive(1, 5'd3, 1, 2'b00, 3'b010, 32'h3, 32'h0, 32'h0);
    step();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    check("wrap.preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(0, 5'd0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    step();
    check("wrap.instret", instret, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if ($urandom_range(0, 3) == 0) in_rd = 5'd0;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 39) == 0);
      step();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
